// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array: op codes, default widths, feeder FSM states.
package systolic_pkg;

  localparam int unsigned OP_WIDTH = 3;

  localparam logic [OP_WIDTH-1:0] OP_WS_FLOW  = 3'b000;
  localparam logic [OP_WIDTH-1:0] OP_W_LOAD   = 3'b001;
  localparam logic [OP_WIDTH-1:0] OP_OS_FLOW  = 3'b100;
  localparam logic [OP_WIDTH-1:0] OP_OS_DRAIN = 3'b110;

  localparam int unsigned DEF_ROWS      = 4;
  localparam int unsigned DEF_ACT_WIDTH = 8;
  localparam int unsigned DEF_WGT_WIDTH = 8;

  typedef enum logic [1:0] {
    StIdle,
    StFlow,
    StFlush
  } feeder_state_e;

endpackage

// File: rtl/systolic_feeder_if.sv
// Upstream column-beat handshake into the systolic feeder.
interface systolic_feeder_if
  import systolic_pkg::*;
#(
  parameter int unsigned ROWS      = DEF_ROWS,
  parameter int unsigned ACT_WIDTH = DEF_ACT_WIDTH,
  parameter int unsigned WGT_WIDTH = DEF_WGT_WIDTH
) ();

  logic                      in_valid;
  logic                      in_ready;
  logic [OP_WIDTH-1:0]       in_op;
  logic                      in_last;
  logic [ROWS*ACT_WIDTH-1:0] in_act;
  logic [ROWS*WGT_WIDTH-1:0] in_wgt;

  modport master (
    output in_valid, in_op, in_last, in_act, in_wgt,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_op, in_last, in_act, in_wgt,
    output in_ready
  );

endinterface

// File: rtl/skew_delay_line.sv
// Fixed-depth shift register; one instance per lane gives that lane its skew.
module skew_delay_line #(
  parameter int unsigned DEPTH = 1,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o
);

  logic [DEPTH-1:0][WIDTH-1:0] pipe_q, pipe_d;

  // Shift: new word enters stage 0, every stage moves one step toward the output.
  always_comb begin
    pipe_d    = pipe_q;
    pipe_d[0] = data_i;
    for (int i = 1; i < DEPTH; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  // Pipe registers, cleared by reset so no stale word survives.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pipe_q <= '0;
    end else begin
      pipe_q <= pipe_d;
    end
  end

  assign data_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/systolic_feeder.sv
// Skews unskewed column beats into a systolic array: row r sees the beat r+1 cycles later.
module systolic_feeder
  import systolic_pkg::*;
#(
  parameter int unsigned ROWS      = DEF_ROWS,
  parameter int unsigned ACT_WIDTH = DEF_ACT_WIDTH,
  parameter int unsigned WGT_WIDTH = DEF_WGT_WIDTH
) (
  input  logic                      clk,
  input  logic                      reset,
  systolic_feeder_if.slave          up,
  output logic [ROWS*ACT_WIDTH-1:0] act_out,
  output logic [ROWS*WGT_WIDTH-1:0] wgt_out,
  output logic [ROWS*OP_WIDTH-1:0]  op_out,
  output logic [ROWS-1:0]           lane_valid,
  output logic                      busy
);

  localparam int unsigned LaneW = 1 + OP_WIDTH + WGT_WIDTH + ACT_WIDTH;
  localparam int unsigned CntW  = (ROWS > 1) ? $clog2(ROWS) : 1;
  // Last flush count value; FLUSH spans counts 0..ROWS-2, i.e. ROWS-1 cycles.
  localparam logic [CntW-1:0] FlushLast = CntW'((ROWS > 1) ? ROWS - 2 : 0);

  feeder_state_e       state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                ready_q, ready_d;
  logic                busy_q, busy_d;
  logic [OP_WIDTH-1:0] last_op_q, last_op_d;
  logic                xfer;

  assign xfer        = up.in_valid & ready_q;
  assign up.in_ready = ready_q;
  assign busy        = busy_q;

  // Next-state logic; ready/busy are decoded from the next state so they leave a flop.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_op_d = xfer ? up.in_op : last_op_q;
    unique case (state_q)
      StIdle, StFlow: begin
        if (xfer) begin
          cnt_d = '0;
          if (!up.in_last) begin
            state_d = StFlow;
          end else if (ROWS > 1) begin
            state_d = StFlush;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StFlush: begin
        if (cnt_q == FlushLast) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
    ready_d = (state_d != StFlush);
    busy_d  = (state_d != StIdle);
  end

  // FSM state, flush counter, held op tag and registered handshake outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      last_op_q <= OP_WS_FLOW;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      last_op_q <= last_op_d;
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_lane
    logic [LaneW-1:0] lane_in, lane_out;

    // Idle cycles inject a bubble that still carries the current op so rows keep their mode.
    assign lane_in = xfer ? {1'b1, up.in_op,
                             up.in_wgt[r*WGT_WIDTH +: WGT_WIDTH],
                             up.in_act[r*ACT_WIDTH +: ACT_WIDTH]}
                          : {1'b0, last_op_q, {WGT_WIDTH{1'b0}}, {ACT_WIDTH{1'b0}}};

    skew_delay_line #(
      .DEPTH(r + 1),
      .WIDTH(LaneW)
    ) u_skew (
      .clk   (clk),
      .reset (reset),
      .data_i(lane_in),
      .data_o(lane_out)
    );

    assign act_out[r*ACT_WIDTH +: ACT_WIDTH] = lane_out[ACT_WIDTH-1:0];
    assign wgt_out[r*WGT_WIDTH +: WGT_WIDTH] = lane_out[ACT_WIDTH +: WGT_WIDTH];
    assign op_out[r*OP_WIDTH +: OP_WIDTH]    = lane_out[ACT_WIDTH+WGT_WIDTH +: OP_WIDTH];
    assign lane_valid[r]                     = lane_out[LaneW-1];
  end

endmodule
